// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: a cache and a bypass agent share one memory
// port. Round-robin on ties, fixed MEM_LAT-cycle access, one-cycle ack.
module mem_arbiter #(
   parameter int unsigned MEM_LAT = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        c_req,
   input  logic        c_we,
   input  logic [11:0] c_addr,
   input  logic [31:0] c_wdata,
   output logic        c_ack,
   output logic [31:0] c_rdata,
   input  logic        ba_req,
   input  logic        ba_we,
   input  logic [11:0] ba_addr,
   input  logic [31:0] ba_wdata,
   output logic        ba_ack,
   output logic [31:0] ba_rdata,
   output logic        mem_trans,
   output logic        mem_memw,
   output logic [11:0] mem_addr,
   output logic [31:0] mem_di,
   input  logic [31:0] mem_dout,
   output logic        busy,
   output logic        grant_id,
   output logic [1:0]  state_dbg
);

   // Request handshake: a requester raises req and holds it until its ack
   // pulse. The request is sampled only while IDLE; everything it carries is
   // latched at that edge, so later input changes cannot disturb the access.

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

   state_t      state, state_nxt;
   logic [3:0]  cnt;
   logic        gnt;
   logic        last_ba;
   logic        lat_we;
   logic [11:0] lat_addr;
   logic [31:0] lat_wdata;
   logic        any_req;
   logic        winner;

   assign any_req = c_req | ba_req;
   // On a tie the requester not served last wins; otherwise the lone requester.
   assign winner  = (c_req && ba_req) ? ~last_ba : ba_req;

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (any_req) state_nxt = S_ACCESS;
         S_ACCESS: if (cnt == 4'd0) state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         cnt       <= 4'd0;
         gnt       <= 1'b0;
         last_ba   <= 1'b1;
         lat_we    <= 1'b0;
         lat_addr  <= 12'd0;
         lat_wdata <= 32'd0;
         c_rdata   <= 32'd0;
         ba_rdata  <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  cnt      <= CNT_INIT;
                  gnt      <= winner;
                  lat_we   <= winner ? ba_we : c_we;
                  lat_addr <= winner ? ba_addr : c_addr;
                  if (winner) lat_wdata <= ba_we ? ba_wdata : 32'd0;
                  else        lat_wdata <= c_we ? c_wdata : 32'd0;
               end
            end
            S_ACCESS: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else if (!lat_we) begin
                  if (gnt) ba_rdata <= mem_dout;
                  else     c_rdata  <= mem_dout;
               end
            end
            S_DONE: last_ba <= gnt;
            default: ;
         endcase
      end
   end

   always_comb begin
      mem_trans = 1'b0;
      mem_memw  = 1'b0;
      mem_addr  = 12'd0;
      mem_di    = 32'd0;
      c_ack     = 1'b0;
      ba_ack    = 1'b0;
      busy      = (state != S_IDLE);
      grant_id  = gnt;
      state_dbg = state;
      if (state == S_ACCESS) begin
         mem_trans = 1'b1;
         mem_memw  = lat_we;
         mem_addr  = lat_addr;
         mem_di    = lat_wdata;
      end
      if (state == S_DONE) begin
         c_ack  = ~gnt;
         ba_ack = gnt;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios on MEM_LAT=2 and MEM_LAT=1 builds,
// then random traffic against a timeline-based reference model.
module tb_mem_arbiter;

   localparam int L = 2;

   logic        clk = 1'b0;
   logic        rstn;
   logic        c_req, c_we, ba_req, ba_we;
   logic [11:0] c_addr, ba_addr;
   logic [31:0] c_wdata, ba_wdata;

   logic        c_ack, ba_ack, mem_trans, mem_memw, busy, grant_id;
   logic [31:0] c_rdata, ba_rdata, mem_di, mem_dout;
   logic [11:0] mem_addr;
   logic [1:0]  state_dbg;

   logic        c_ack_1, ba_ack_1, mem_trans_1, mem_memw_1, busy_1, grant_id_1;
   logic [31:0] c_rdata_1, ba_rdata_1, mem_di_1, mem_dout_1;
   logic [11:0] mem_addr_1;
   logic [1:0]  state_dbg_1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_fn(input logic [11:0] a);
      if (a == 12'h123) return 32'hDEADBEEF;
      return {a, 8'h5A, ~a};
   endfunction

   // Memory returns junk outside an access so late/early capture shows up.
   assign mem_dout   = mem_trans   ? mem_fn(mem_addr)   : 32'hBAD0BAD0;
   assign mem_dout_1 = mem_trans_1 ? mem_fn(mem_addr_1) : 32'hBAD0BAD0;

   mem_arbiter #(.MEM_LAT(L)) u_dut (
      .clk(clk), .rstn(rstn),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_ack(c_ack), .c_rdata(c_rdata),
      .ba_req(ba_req), .ba_we(ba_we), .ba_addr(ba_addr), .ba_wdata(ba_wdata),
      .ba_ack(ba_ack), .ba_rdata(ba_rdata),
      .mem_trans(mem_trans), .mem_memw(mem_memw), .mem_addr(mem_addr),
      .mem_di(mem_di), .mem_dout(mem_dout),
      .busy(busy), .grant_id(grant_id), .state_dbg(state_dbg)
   );

   mem_arbiter #(.MEM_LAT(1)) u_dut1 (
      .clk(clk), .rstn(rstn),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_ack(c_ack_1), .c_rdata(c_rdata_1),
      .ba_req(ba_req), .ba_we(ba_we), .ba_addr(ba_addr), .ba_wdata(ba_wdata),
      .ba_ack(ba_ack_1), .ba_rdata(ba_rdata_1),
      .mem_trans(mem_trans_1), .mem_memw(mem_memw_1), .mem_addr(mem_addr_1),
      .mem_di(mem_di_1), .mem_dout(mem_dout_1),
      .busy(busy_1), .grant_id(grant_id_1), .state_dbg(state_dbg_1)
   );

   // ---------------- reference model (transaction timeline) ----------------
   int          m_edge, m_start;
   logic        m_owner, m_we, m_last, m_gid;
   logic [11:0] m_addr;
   logic [31:0] m_wdata, m_crd, m_brd;

   task automatic m_reset;
      m_edge  = 0;
      m_start = -100;
      m_owner = 1'b0;
      m_we    = 1'b0;
      m_addr  = 12'd0;
      m_wdata = 32'd0;
      m_last  = 1'b1;
      m_gid   = 1'b0;
      m_crd   = 32'd0;
      m_brd   = 32'd0;
   endtask

   // An access granted at edge s occupies the L cycles after edges s..s+L-1,
   // acks in the cycle after edge s+L, and the next grant can be at s+L+2.
   task automatic model_step;
      int d;
      m_edge++;
      d = m_edge - m_start;
      if (d == L && !m_we) begin
         if (m_owner) m_brd = mem_fn(m_addr);
         else         m_crd = mem_fn(m_addr);
      end
      if (d == L + 1) m_last = m_owner;
      if (d >= L + 2 && (c_req || ba_req)) begin
         if (c_req && ba_req) m_owner = (m_last == 1'b1) ? 1'b0 : 1'b1;
         else                 m_owner = ba_req;
         m_start = m_edge;
         m_gid   = m_owner;
         m_we    = m_owner ? ba_we : c_we;
         m_addr  = m_owner ? ba_addr : c_addr;
         m_wdata = m_owner ? ba_wdata : c_wdata;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_inputs;
      c_req = 1'b0; c_we = 1'b0; c_addr = 12'd0; c_wdata = 32'd0;
      ba_req = 1'b0; ba_we = 1'b0; ba_addr = 12'd0; ba_wdata = 32'd0;
   endtask

   task automatic do_reset;
      rstn = 1'b1;
      clear_inputs();
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      rstn = 1'b1;
      clear_inputs();
      #1;
      checks++;
      if ({c_ack, ba_ack, c_rdata, ba_rdata, mem_trans, mem_memw, mem_addr, mem_di, busy, grant_id} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got ack=%b%b rd=%h/%h trans=%b w=%b addr=%h di=%h busy=%b gid=%b, want all 0",
                  c_ack, ba_ack, c_rdata, ba_rdata, mem_trans, mem_memw, mem_addr, mem_di, busy, grant_id);
      end
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, mem_trans, c_ack, ba_ack} !== 4'b0000) begin
         errors++;
         $display("FAIL idle_after_reset: got busy/trans/acks=%b want 0000", {busy, mem_trans, c_ack, ba_ack});
      end
   endtask

   task automatic test_cache_read;
      do_reset();
      c_req = 1'b1; c_we = 1'b0; c_addr = 12'h123; c_wdata = 32'hFFFF_FFFF;
      for (int i = 0; i < L; i++) begin
         @(negedge clk);
         checks++;
         if ({mem_trans, mem_memw, mem_addr, mem_di, busy, c_ack, grant_id} !== {1'b1, 1'b0, 12'h123, 32'h0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL cache_read_access[%0d]: got trans=%b w=%b addr=%h di=%h busy=%b ack=%b gid=%b want 1 0 123 0 1 0 0",
                     i, mem_trans, mem_memw, mem_addr, mem_di, busy, c_ack, grant_id);
         end
      end
      @(negedge clk);
      checks++;
      if ({mem_trans, c_ack, ba_ack, busy} !== 4'b0101) begin
         errors++;
         $display("FAIL cache_read_ack: got trans/c_ack/ba_ack/busy=%b want 0101", {mem_trans, c_ack, ba_ack, busy});
      end
      checks++;
      if ({c_rdata, ba_rdata} !== {32'hDEADBEEF, 32'h0}) begin
         errors++;
         $display("FAIL cache_read_data: got c_rdata=%h ba_rdata=%h want deadbeef 0", c_rdata, ba_rdata);
      end
      c_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({c_ack, busy} !== 2'b00) begin
         errors++;
         $display("FAIL cache_read_single_pulse: got ack/busy=%b want 00", {c_ack, busy});
      end
   endtask

   task automatic test_bypass_write;
      ba_req = 1'b1; ba_we = 1'b1; ba_addr = 12'h0F0; ba_wdata = 32'h0000_0055;
      for (int i = 0; i < L; i++) begin
         @(negedge clk);
         checks++;
         if ({mem_trans, mem_memw, mem_addr, mem_di, grant_id} !== {1'b1, 1'b1, 12'h0F0, 32'h55, 1'b1}) begin
            errors++;
            $display("FAIL bypass_write_access[%0d]: got trans=%b w=%b addr=%h di=%h gid=%b want 1 1 0f0 55 1",
                     i, mem_trans, mem_memw, mem_addr, mem_di, grant_id);
         end
      end
      @(negedge clk);
      checks++;
      if ({c_ack, ba_ack, mem_trans, mem_memw} !== 4'b0100) begin
         errors++;
         $display("FAIL bypass_write_ack: got c_ack/ba_ack/trans/w=%b want 0100", {c_ack, ba_ack, mem_trans, mem_memw});
      end
      checks++;
      if ({c_rdata, ba_rdata} !== {32'hDEADBEEF, 32'h0}) begin
         errors++;
         $display("FAIL bypass_write_rdata: got c_rdata=%h ba_rdata=%h want deadbeef 0", c_rdata, ba_rdata);
      end
      ba_req = 1'b0; ba_we = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_round_robin;
      logic        own;
      int          p;
      logic [11:0] a;
      do_reset();
      c_req = 1'b1; c_addr = 12'h111;
      ba_req = 1'b1; ba_addr = 12'h222;
      for (int j = 0; j < 4 * (L + 2); j++) begin
         @(negedge clk);
         p   = j % (L + 2);
         own = ((j / (L + 2)) % 2) == 1;
         a   = own ? 12'h222 : 12'h111;
         if (p < L) begin
            checks++;
            if ({mem_trans, mem_addr, grant_id} !== {1'b1, a, own}) begin
               errors++;
               $display("FAIL rr_grant[%0d]: got trans=%b addr=%h gid=%b want 1 %h %b", j, mem_trans, mem_addr, grant_id, a, own);
            end
         end else if (p == L) begin
            checks++;
            if ({c_ack, ba_ack} !== {~own, own}) begin
               errors++;
               $display("FAIL rr_ack[%0d]: got c_ack/ba_ack=%b%b want %b%b", j, c_ack, ba_ack, ~own, own);
            end
            checks++;
            if ((own ? ba_rdata : c_rdata) !== mem_fn(a)) begin
               errors++;
               $display("FAIL rr_rdata[%0d]: got %h want %h", j, own ? ba_rdata : c_rdata, mem_fn(a));
            end
         end else begin
            checks++;
            if ({c_ack, ba_ack, mem_trans, busy} !== 4'b0000) begin
               errors++;
               $display("FAIL rr_idle[%0d]: got acks/trans/busy=%b want 0000", j, {c_ack, ba_ack, mem_trans, busy});
            end
         end
      end
      c_req = 1'b0; ba_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_addr_hold;
      c_req = 1'b1; c_we = 1'b0; c_addr = 12'h010;
      for (int i = 0; i < L; i++) begin
         @(negedge clk);
         checks++;
         if ({mem_trans, mem_memw, mem_addr, mem_di} !== {1'b1, 1'b0, 12'h010, 32'h0}) begin
            errors++;
            $display("FAIL addr_hold[%0d]: got trans=%b w=%b addr=%h di=%h want 1 0 010 0", i, mem_trans, mem_memw, mem_addr, mem_di);
         end
         if (i == 0) begin
            c_addr = 12'h020; c_we = 1'b1; c_wdata = $urandom;
         end
      end
      @(negedge clk);
      checks++;
      if ({c_ack, c_rdata} !== {1'b1, mem_fn(12'h010)}) begin
         errors++;
         $display("FAIL addr_hold_ack: got ack=%b rdata=%h want 1 %h", c_ack, c_rdata, mem_fn(12'h010));
      end
      c_req = 1'b0; c_we = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_mid_reset;
      c_req = 1'b1; c_we = 1'b0; c_addr = 12'h030;
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      checks++;
      if ({c_ack, ba_ack, c_rdata, ba_rdata, mem_trans, mem_memw, mem_addr, mem_di, busy, grant_id} !== '0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got ack=%b%b rd=%h/%h trans=%b addr=%h busy=%b want all 0",
                  c_ack, ba_ack, c_rdata, ba_rdata, mem_trans, mem_addr, busy);
      end
      @(negedge clk);
      checks++;
      if ({c_ack, ba_ack, busy} !== 3'b000) begin
         errors++;
         $display("FAIL mid_reset_no_ack: got acks/busy=%b want 000", {c_ack, ba_ack, busy});
      end
      rstn = 1'b0;
      for (int i = 0; i < L; i++) begin
         @(negedge clk);
         checks++;
         if ({mem_trans, mem_addr, c_ack} !== {1'b1, 12'h030, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset_restart[%0d]: got trans=%b addr=%h ack=%b want 1 030 0", i, mem_trans, mem_addr, c_ack);
         end
      end
      @(negedge clk);
      checks++;
      if ({c_ack, c_rdata} !== {1'b1, mem_fn(12'h030)}) begin
         errors++;
         $display("FAIL mid_reset_ack: got ack=%b rdata=%h want 1 %h", c_ack, c_rdata, mem_fn(12'h030));
      end
      c_req = 1'b0;
      @(negedge clk);
   endtask

   // Also covers dropping req mid-access on the MEM_LAT=2 instance.
   task automatic test_lat1;
      do_reset();
      c_req = 1'b1; c_we = 1'b0; c_addr = 12'h0AB;
      @(negedge clk);
      checks++;
      if ({mem_trans_1, mem_addr_1, c_ack_1} !== {1'b1, 12'h0AB, 1'b0}) begin
         errors++;
         $display("FAIL lat1_access: got trans=%b addr=%h ack=%b want 1 0ab 0", mem_trans_1, mem_addr_1, c_ack_1);
      end
      @(negedge clk);
      checks++;
      if ({mem_trans_1, c_ack_1, c_rdata_1} !== {1'b0, 1'b1, mem_fn(12'h0AB)}) begin
         errors++;
         $display("FAIL lat1_ack: got trans=%b ack=%b rdata=%h want 0 1 %h", mem_trans_1, c_ack_1, c_rdata_1, mem_fn(12'h0AB));
      end
      c_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({c_ack_1, busy_1} !== 2'b00) begin
         errors++;
         $display("FAIL lat1_idle: got ack/busy=%b want 00", {c_ack_1, busy_1});
      end
      checks++;
      if ({c_ack, c_rdata} !== {1'b1, mem_fn(12'h0AB)}) begin
         errors++;
         $display("FAIL dropped_req_ack: got ack=%b rdata=%h want 1 %h", c_ack, c_rdata, mem_fn(12'h0AB));
      end
      @(negedge clk);
   endtask

   task automatic test_random;
      int    d;
      logic  acc, dn;
      logic [45:0] e_mem;
      do_reset();
      m_reset();
      for (int n = 0; n < 800; n++) begin
         c_req    = ($urandom_range(0, 2) != 0);
         c_we     = 1'($urandom_range(0, 1));
         c_addr   = 12'($urandom);
         c_wdata  = $urandom;
         ba_req   = ($urandom_range(0, 2) != 0);
         ba_we    = 1'($urandom_range(0, 1));
         ba_addr  = 12'($urandom);
         ba_wdata = $urandom;
         @(posedge clk);
         model_step();
         @(negedge clk);
         d   = m_edge - m_start;
         acc = (d >= 0) && (d < L);
         dn  = (d == L);
         e_mem = acc ? {1'b1, m_we, m_addr, (m_we ? m_wdata : 32'd0)} : '0;
         checks++;
         if ({mem_trans, mem_memw, mem_addr, mem_di} !== e_mem) begin
            errors++;
            $display("FAIL rnd_mem[%0d]: got %h want %h", n, {mem_trans, mem_memw, mem_addr, mem_di}, e_mem);
         end
         checks++;
         if ({c_ack, ba_ack, busy, grant_id} !== {dn & ~m_owner, dn & m_owner, acc | dn, m_gid}) begin
            errors++;
            $display("FAIL rnd_ctrl[%0d]: got acks/busy/gid=%b want %b", n, {c_ack, ba_ack, busy, grant_id},
                     {dn & ~m_owner, dn & m_owner, acc | dn, m_gid});
         end
         checks++;
         if ({c_rdata, ba_rdata} !== {m_crd, m_brd}) begin
            errors++;
            $display("FAIL rnd_rdata[%0d]: got %h/%h want %h/%h", n, c_rdata, ba_rdata, m_crd, m_brd);
         end
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_cache_read();
      test_bypass_write();
      test_round_robin();
      test_addr_hold();
      test_mid_reset();
      test_lat1();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
